// File: rtl/fir_da_pkg.sv
// Shared definitions for the bit-serial distributed-arithmetic FIR sequencer.
//   state_t           : sequencer FSM state
//   bit_cnt_width()   : width of the sample-bit counter for a given sample width
package fir_da_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  // Width needed to count sample bits 0..sample_width-1 (never zero).
  function automatic int unsigned bit_cnt_width(input int unsigned sample_width);
    return (sample_width > 1) ? $clog2(sample_width) : 1;
  endfunction

endpackage

// File: rtl/fir_da_sequencer.sv
// Bit-serial distributed-arithmetic FIR core in front of an external offset-binary
// coefficient ROM. Keeps the tap delay line, walks the sample bits LSB first as the
// ROM address, and shift-accumulates the ROM words into one output per sample.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/ready    sample handshake; in_sample is the new x[n]
//   rom_address       bit k = bit b of tap[k]; rom_en high only while shifting
//   rom_data          combinational ROM word for rom_address (signed)
//   out_valid/ready   result handshake; out_data = sum h_k*x[n-k]
module fir_da_sequencer
  import fir_da_pkg::*;
#(
  parameter int unsigned sample_width  = 16,
  parameter int unsigned address_width = 3,
  parameter int unsigned word_width    = 16,
  parameter int          offset        = 0,
  parameter int unsigned acc_width     = word_width + sample_width + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [sample_width-1:0] in_sample,
  output logic [address_width-1:0]      rom_address,
  output logic                           rom_en,
  input  logic signed [word_width-1:0]   rom_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [acc_width-1:0]    out_data
);

  localparam int unsigned CntW = bit_cnt_width(sample_width);
  localparam logic [CntW-1:0] LastBit = CntW'(sample_width - 1);
  localparam logic signed [acc_width-1:0] OffsetExt = acc_width'(offset);

  state_t                         r_state, w_state_d;
  logic signed [sample_width-1:0] r_taps [address_width];
  logic signed [acc_width-1:0]    r_acc, w_acc_d;
  logic signed [acc_width-1:0]    r_out;
  logic [CntW-1:0]                r_bit, w_bit_d;
  logic                           w_accept;
  logic                           w_load_out;
  logic signed [acc_width-1:0]    w_rom_ext;
  logic signed [acc_width-1:0]    w_rom_shifted;

  assign in_ready      = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept      = in_valid && in_ready;
  assign rom_en        = (r_state == SHIFT);
  assign out_valid     = (r_state == DONE);
  assign out_data      = r_out;
  assign w_rom_ext     = acc_width'(rom_data);
  assign w_rom_shifted = w_rom_ext <<< r_bit;

  // Address bit k carries the current sample bit of tap k.
  always_comb begin
    rom_address = '0;
    if (r_state == SHIFT) begin
      for (int unsigned k = 0; k < address_width; k++) begin
        rom_address[k] = r_taps[k][r_bit];
      end
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_bit_d    = r_bit;
    w_load_out = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_d = SHIFT;
          w_acc_d   = OffsetExt;
          w_bit_d   = '0;
        end
      end
      SHIFT: begin
        if (r_bit == LastBit) begin
          // Sign bit of two's complement carries negative weight.
          w_acc_d    = r_acc - w_rom_shifted;
          w_state_d  = DONE;
          w_load_out = 1'b1;
        end else begin
          w_acc_d = r_acc + w_rom_shifted;
          w_bit_d = r_bit + CntW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept) begin
            w_state_d = SHIFT;
            w_acc_d   = OffsetExt;
            w_bit_d   = '0;
          end else begin
            w_state_d = IDLE;
          end
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_bit   <= '0;
      r_out   <= '0;
      for (int unsigned k = 0; k < address_width; k++) begin
        r_taps[k] <= '0;
      end
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
      r_bit   <= w_bit_d;
      if (w_load_out) begin
        r_out <= w_acc_d;
      end
      if (w_accept) begin
        r_taps[0] <= in_sample;
        for (int unsigned k = 1; k < address_width; k++) begin
          r_taps[k] <= r_taps[k-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_da_sequencer.sv
// Directed bench for fir_da_sequencer with N=3, B=16, h={2,4,6}, offset=-6.
// The ROM is modelled inline: rom[a] = 1/2*sum(+-h_k) = -6 + sum of h_k where a[k]=1.
module tb_fir_da_sequencer;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_sample;
  logic [2:0]         rom_address;
  logic               rom_en;
  logic signed [15:0] rom_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [32:0] out_data;

  int total = 0;
  int bad   = 0;

  fir_da_sequencer #(
    .sample_width (16),
    .address_width(3),
    .word_width   (16),
    .offset       (-6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .rom_address(rom_address),
    .rom_en     (rom_en),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rom_data = 16'(-6 + (rom_address[0] ? 2 : 0) + (rom_address[1] ? 4 : 0)
                      + (rom_address[2] ? 6 : 0));
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Drives one sample from IDLE, waits (bounded) for the result and releases it.
  task automatic run_sample(input logic signed [15:0] x, output int lat,
                            output logic signed [32:0] y);
    in_valid  = 1'b1;
    in_sample = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    y = out_data;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_sample = '0; out_ready = 1'b0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if (rom_en !== 1'b0) begin bad++;
      $display("FAIL reset_rom_en: got %b want 0", rom_en); end
    total++; if (rom_address !== 3'b000) begin bad++;
      $display("FAIL reset_rom_address: got %b want 000", rom_address); end
    total++; if (out_data !== 33'sd0) begin bad++;
      $display("FAIL reset_out_data: got %0d want 0", out_data); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zeros();
    int lat;
    logic signed [32:0] y;
    for (int i = 0; i < 3; i++) begin
      run_sample(16'sd0, lat, y);
      total++; if (lat !== 16) begin bad++;
        $display("FAIL zeros_latency[%0d]: got %0d want 16", i, lat); end
      total++; if (y !== 33'sd0) begin bad++;
        $display("FAIL zeros_data[%0d]: got %0d want 0", i, y); end
    end
  endtask

  task automatic test_impulse();
    logic signed [15:0] xs [6] = '{16'sd1, 16'sd0, 16'sd0, -16'sd1, 16'sd0, 16'sd0};
    logic signed [32:0] ex [6] = '{33'sd2, 33'sd4, 33'sd6, -33'sd2, -33'sd4, -33'sd6};
    int lat;
    logic signed [32:0] y;
    for (int i = 0; i < 6; i++) begin
      run_sample(xs[i], lat, y);
      total++; if (lat !== 16) begin bad++;
        $display("FAIL impulse_latency[%0d]: got %0d want 16", i, lat); end
      total++; if (y !== ex[i]) begin bad++;
        $display("FAIL impulse_data[%0d]: got %0d want %0d", i, y, ex[i]); end
    end
  endtask

  task automatic test_min_sample();
    logic signed [32:0] ex [3] = '{-33'sd65536, -33'sd196608, -33'sd393216};
    int lat;
    logic signed [32:0] y;
    for (int i = 0; i < 3; i++) begin
      run_sample(-16'sd32768, lat, y);
      total++; if (y !== ex[i]) begin bad++;
        $display("FAIL min_data[%0d]: got %0d want %0d", i, y, ex[i]); end
    end
  endtask

  // Taps on entry: {-32768,-32768,-32768}.
  task automatic test_back_to_back();
    int lat;
    logic stable_ok;
    in_valid = 1'b1; in_sample = 16'sd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (out_data !== -33'sd327678) begin bad++;
      $display("FAIL bp_data: got %0d want -327678", out_data); end
    stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_data !== -33'sd327678 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable_ok = 1'b0;
    end
    total++; if (stable_ok !== 1'b1) begin bad++;
      $display("FAIL bp_hold: got data=%0d in_ready=%b out_valid=%b want -327678 0 1",
               out_data, in_ready, out_valid); end
    out_ready = 1'b1; in_valid = 1'b1; in_sample = 16'sd2;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL bp_release_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (rom_en !== 1'b1 || out_valid !== 1'b0) begin bad++;
      $display("FAIL b2b_no_bubble: got rom_en=%b out_valid=%b want 1 0", rom_en, out_valid); end
    total++; if (out_data !== -33'sd327678) begin bad++;
      $display("FAIL b2b_out_hold: got %0d want -327678", out_data); end
    // Taps {2,1,-32768}: bit 0 is 0,1,0.
    total++; if (rom_address !== 3'b010) begin bad++;
      $display("FAIL b2b_rom_address: got %b want 010", rom_address); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== 16) begin bad++;
      $display("FAIL b2b_latency: got %0d want 16", lat); end
    total++; if (out_data !== -33'sd196600) begin bad++;
      $display("FAIL b2b_data: got %0d want -196600", out_data); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Taps on entry: {2,1,-32768}.
  task automatic test_shift_ignore();
    int lat;
    logic signed [32:0] y;
    logic ready_low;
    in_valid = 1'b1; in_sample = 16'sd3;
    @(posedge clk); #1;
    in_sample = 16'sh1234;
    ready_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0) ready_low = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++; if (ready_low !== 1'b1) begin bad++;
      $display("FAIL shift_in_ready: got 1 want 0"); end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    total++; if (out_data !== 33'sd20) begin bad++;
      $display("FAIL shift_data: got %0d want 20", out_data); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    // Taps {0,3,2} only if nothing was taken during SHIFT.
    run_sample(16'sd0, lat, y);
    total++; if (y !== 33'sd24) begin bad++;
      $display("FAIL shift_taps_kept: got %0d want 24", y); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic signed [32:0] y;
    in_valid = 1'b1; in_sample = 16'sd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    total++; if (rom_en !== 1'b1) begin bad++;
      $display("FAIL mid_pre_rom_en: got %b want 1", rom_en); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || rom_en !== 1'b0) begin bad++;
      $display("FAIL mid_async: got out_valid=%b rom_en=%b want 0 0", out_valid, rom_en); end
    total++; if (rom_address !== 3'b000 || in_ready !== 1'b1) begin bad++;
      $display("FAIL mid_async_addr: got addr=%b in_ready=%b want 000 1", rom_address,
               in_ready); end
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_sample(16'sd5, lat, y);
    total++; if (lat !== 16) begin bad++;
      $display("FAIL mid_next_latency: got %0d want 16", lat); end
    total++; if (y !== 33'sd10) begin bad++;
      $display("FAIL mid_next_data: got %0d want 10", y); end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_impulse();
    test_min_sample();
    test_back_to_back();
    test_shift_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
